// File: rtl/axi_pkg.sv
// Shared AXI4 types and constants for the memory responder and its beat sequencer.
package axi_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        BurstFixed = 2'd0,
        BurstIncr  = 2'd1,
        BurstWrap  = 2'd2
    } burst_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWrData,
        StWrResp,
        StRdData
    } resp_state_e;

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Per-burst beat sequencer: holds the current word index, length and beat count, and reports
// the index of the following beat, the last-beat flag and whether the current index is in range.
module axi_beat_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] start_idx_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] idx_o,
    output logic [ADDR_WIDTH-1:0] step_idx_o,
    output logic                  last_o,
    output logic                  in_range_o
);

    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            len_q, len_d;
    burst_e                burst_q, burst_d;

    always_comb begin
        // WRAP is deliberately treated as INCR; only FIXED holds the index.
        step_idx_o = (burst_q == BurstFixed) ? idx_q : idx_q + ADDR_WIDTH'(1);
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        burst_d    = burst_q;
        if (load_i) begin
            idx_d   = start_idx_i;
            cnt_d   = '0;
            len_d   = len_i;
            burst_d = burst_e'(burst_i);
        end else if (advance_i) begin
            idx_d = step_idx_o;
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            burst_q <= BurstIncr;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            burst_q <= burst_d;
        end
    end

    assign idx_o      = idx_q;
    assign last_o     = (cnt_q == len_q);
    assign in_range_o = (idx_q < ADDR_WIDTH'(MEM_DEPTH));

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate memory: serves one write (AW/W/B) or read (AR/R) burst at a time from a
// word array. Define AXI_RESP_STALL_EN to inject pseudo-random W/R/B stalls from an 8-bit LFSR.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    resp_state_e           state_q, state_d;
    logic                  grant_wr_q, grant_wr_d;  // last grant: 1 = write, 0 = read
    logic                  err_q, err_d;
    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  wr_load, wr_adv, rd_load, rd_adv, mem_we;
    logic [ADDR_WIDTH-1:0] aw_idx, ar_idx;
    logic [ADDR_WIDTH-1:0] wr_idx, wr_step_idx, rd_idx, rd_step_idx;
    logic                  wr_last, wr_in_range, rd_last, rd_in_range;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  fetch_in_range;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic                  w_stall, r_stall, b_stall;

    assign aw_idx = (awaddr - MEM_BASE) >> 2;
    assign ar_idx = (araddr - MEM_BASE) >> 2;

    axi_beat_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_wr_gen (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .load_i      (wr_load),
        .start_idx_i (aw_idx),
        .len_i       (awlen),
        .burst_i     (awburst),
        .advance_i   (wr_adv),
        .idx_o       (wr_idx),
        .step_idx_o  (wr_step_idx),
        .last_o      (wr_last),
        .in_range_o  (wr_in_range)
    );

    axi_beat_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_rd_gen (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .load_i      (rd_load),
        .start_idx_i (ar_idx),
        .len_i       (arlen),
        .burst_i     (arburst),
        .advance_i   (rd_adv),
        .idx_o       (rd_idx),
        .step_idx_o  (rd_step_idx),
        .last_o      (rd_last),
        .in_range_o  (rd_in_range)
    );

    // Read data is fetched one beat ahead so rdata_q is ready when rvalid rises.
    assign fetch_idx      = (state_q == StIdle) ? ar_idx : rd_step_idx;
    assign fetch_in_range = (fetch_idx < ADDR_WIDTH'(MEM_DEPTH));
    assign fetch_word     = fetch_in_range ? mem_q[fetch_idx[IdxWidth-1:0]] : '0;

`ifdef AXI_RESP_STALL_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign w_stall = lfsr_q[0];
    assign r_stall = lfsr_q[0];
    assign b_stall = lfsr_q[1];
`else
    assign w_stall = 1'b0;
    assign r_stall = 1'b0;
    assign b_stall = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_wr_d = grant_wr_q;
        err_d      = err_q;
        bvalid_d   = bvalid_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        awready    = 1'b0;
        arready    = 1'b0;
        wready     = 1'b0;
        wr_load    = 1'b0;
        wr_adv     = 1'b0;
        rd_load    = 1'b0;
        rd_adv     = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                awready = awvalid && (!arvalid || !grant_wr_q);
                arready = arvalid && (!awvalid || grant_wr_q);
                if (awready) begin
                    wr_load    = 1'b1;
                    err_d      = 1'b0;
                    grant_wr_d = 1'b1;
                    state_d    = StWrData;
                end else if (arready) begin
                    rd_load    = 1'b1;
                    grant_wr_d = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = fetch_word;
                    rresp_d    = fetch_in_range ? RespOkay : RespSlverr;
                    state_d    = StRdData;
                end
            end
            StWrData: begin
                wready = !w_stall;
                if (wvalid && wready) begin
                    wr_adv = 1'b1;
                    mem_we = wr_in_range;
                    if (!wr_in_range || (wlast != wr_last)) begin
                        err_d = 1'b1;
                    end
                    if (wr_last) begin
                        state_d  = StWrResp;
                        bvalid_d = !b_stall;
                    end
                end
            end
            StWrResp: begin
                if (bvalid_q && bready) begin
                    bvalid_d = 1'b0;
                    state_d  = StIdle;
                end else if (!bvalid_q) begin
                    bvalid_d = !b_stall;
                end
            end
            StRdData: begin
                if (rvalid_q && rready) begin
                    if (rd_last) begin
                        rvalid_d = 1'b0;
                        rdata_d  = '0;
                        rresp_d  = RespOkay;
                        state_d  = StIdle;
                    end else begin
                        rd_adv   = 1'b1;
                        rdata_d  = fetch_word;
                        rresp_d  = fetch_in_range ? RespOkay : RespSlverr;
                        rvalid_d = !r_stall;
                    end
                end else if (!rvalid_q) begin
                    rvalid_d = !r_stall;
                end
            end
            default: state_d = StIdle;
        endcase

        if (sys_rst) begin
            awready = 1'b0;
            arready = 1'b0;
            wready  = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            grant_wr_q <= 1'b0;
            err_q      <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
        end else begin
            state_q    <= state_d;
            grant_wr_q <= grant_wr_d;
            err_q      <= err_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (wstrb[b]) begin
                    mem_q[wr_idx[IdxWidth-1:0]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign bvalid = bvalid_q && !sys_rst;
    assign bresp  = (bvalid_q && err_q && !sys_rst) ? RespSlverr : RespOkay;
    assign rvalid = rvalid_q && !sys_rst;
    assign rlast  = rvalid_q && rd_last && !sys_rst;
    assign rdata  = sys_rst ? '0 : rdata_q;
    assign rresp  = sys_rst ? RespOkay : rresp_q;

    logic unused_sigs;
    assign unused_sigs = ^{wr_step_idx, rd_idx, rd_in_range};

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 subordinate memory model on the sys_clk domain; the responder end of the DMA page-fault (read) and write-back (write) bursts.
- Accepts one burst at a time, either an AW/W/B write or an AR/R read.
- Backs the bursts with a word-addressed internal array.
- Used as the system-memory stand-in for DMA and cache-refill benches, and as a synthesizable scratch memory.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; fixed to 32 for this revision (4 byte strobes).
- MEM_DEPTH, 1024, number of 32-bit words.
- MEM_BASE, 32'h0000_0000, byte address of word 0.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- awaddr  in  ADDR_WIDTH  write burst start byte address.
- awlen  in  8  write beats minus 1.
- awburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- awvalid  in  1  / awready  out  1  AW handshake.
- wdata  in  32  / wstrb  in  4  / wlast  in  1  write beat data, strobes, last flag.
- wvalid  in  1  / wready  out  1  W handshake.
- bresp  out  2  / bvalid  out  1  / bready  in  1  write response.
- araddr  in  ADDR_WIDTH  / arlen  in  8  / arburst  in  2  read burst request.
- arvalid  in  1  / arready  out  1  AR handshake.
- rdata  out  32  / rresp  out  2  / rlast  out  1  read beat outputs.
- rvalid  out  1  / rready  in  1  R handshake.

Behaviour:
- Reset:
  - One clock, sys_clk; reset is synchronous and active-high (sys_rst).
  - While sys_rst is high: awready, arready, wready, bvalid, rvalid, rlast = 0; bresp, rresp = 0; rdata = 0.
  - On reset: state = IDLE, beat counter = 0, last_grant = READ.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; the next cycle is IDLE.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE arbitration:
  - awready = awvalid && (!arvalid || last_grant==READ).
  - arready = arvalid && (!awvalid || last_grant==WRITE).
  - Round-robin on a simultaneous request; the first tie after reset grants the write.
- AW handshake:
  - Latch word index = (awaddr-MEM_BASE)>>2 (low 2 bits ignored), awlen, awburst.
  - Clear the error flag, set last_grant = WRITE, go to WR_DATA.
- WR_DATA:
  - wready = 1.
  - Each W handshake writes the strobed bytes to the current word.
  - Beat counter increments by 1.
  - Word index increments by 1 for INCR/WRAP (WRAP is treated as INCR) and holds for FIXED.
  - Exactly awlen+1 beats are accepted. After the beat where counter==awlen, go to WR_RESP.
  - wlast must equal (counter==awlen). A mismatch on any beat sets the error flag.
- WR_RESP:
  - bvalid = 1 from the cycle after the final W handshake.
  - bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - Hold until bready; on the handshake go to IDLE (awready can assert the next cycle).
- AR handshake:
  - Latch the same fields and set last_grant = READ.
  - Load rdata with word[index] in the same clock.
  - rvalid rises on the next cycle (1-cycle latency). Go to RD_DATA.
- RD_DATA:
  - rvalid, rdata, rresp and rlast are held stable until rready.
  - On a handshake with counter<arlen: advance the index and load the next word; rvalid stays high (back-to-back beats).
  - rlast = (counter==arlen).
  - On the handshake with rlast=1: rvalid drops next cycle and the FSM goes to IDLE.
- Range check (per beat):
  - A word index >= MEM_DEPTH (address below MEM_BASE wraps high as unsigned) is out of range.
  - Out-of-range write beats are dropped and set the error flag.
  - Out-of-range read beats return rdata = 0 with rresp = SLVERR; in-range beats return OKAY.
- Counter width is 8 bits; awlen=255 gives 256 beats with no overflow into the next burst.

Optional Feature:
- Macro: AXI_RESP_STALL_EN.
- With the macro:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) steps every cycle.
  - In WR_DATA, wready = !lfsr[0].
  - In RD_DATA, a new beat (after the first) is withheld while lfsr[0]==1, so rvalid drops between beats.
  - An asserted rvalid never drops before its handshake.
  - bvalid assertion is delayed while lfsr[1]==1.
- Without the macro: no stalls, and behaviour is exactly as above.

Decomposition:
- Package axi_pkg holds:
  - Burst type enum (FIXED/INCR/WRAP).
  - Response constants (OKAY 2'b00, SLVERR 2'b10).
  - Responder FSM state enum.
  - ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module axi_beat_addr_gen contains:
  - Latched start index, burst type, length and beat counter.
  - Next-index, last-beat and in-range outputs.
- axi_beat_addr_gen is shared by the write and read paths (one instance each).

Test Plan:
- Write burst: awaddr=30, awlen=22, wdata=beat number, wstrb=4'hF, wlast on beat 22 -> 23 W handshakes, then one bvalid with bresp=00; words 7..29 = 0..22.
- Read back: araddr=28, arlen=7 -> rvalid the cycle after arready; 8 beats rdata 0..7, rlast only on beat 8, rresp=00.
- Simultaneous awvalid and arvalid after reset -> write granted first; the read is granted next, after B completes.
- Early wlast: awlen=3 with wlast on beat 2 -> still 4 beats accepted, bresp=10.
- Out-of-range read: araddr=MEM_BASE+4*1022, arlen=3 -> beats 1-2 OKAY with data; beats 3-4 rdata=0, rresp=10.
- Reset pulse during beat 5 of an 8-beat read -> rvalid=0 the next cycle, FSM IDLE; a new AR is accepted afterwards.
